user_module_341063825089364563: RTL and testbench

- 8-bit programmable sequence generator for the shared 8-in/8-out user-module slot.
- The slot's input bus carries clock, reset, a 2-bit mode and a 4-bit data nibble.
- The output bus always shows the 8-bit state register Q.
- Modes: stepped up-count, stepped down-count, maximal-length LFSR, and nibble-serial load.

---
 rtl/user_module_341063825089364563_if.sv | 13 +
 rtl/user_module_341063825089364563.sv | 67 ++++++
 tb/tb_user_module_341063825089364563.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/user_module_341063825089364563_if.sv
// Slot bus for the 8-in/8-out user-module position.
// io_in  : [0] clock, [1] active-low async reset, [3:2] mode, [7:4] data nibble.
// io_out : current state register Q.
// Handshake: none. Q is presented continuously and changes only on a rising
// clock edge or on reset assertion, so a sampler may read io_out at any
// point away from the rising edge.
interface user_module_341063825089364563_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);
endinterface

// File: rtl/user_module_341063825089364563.sv
// 8-bit programmable sequence generator: stepped up/down counter,
// maximal-length Fibonacci LFSR and nibble-serial loader.
// Q is the only state; io_out shows it directly with no output pipeline.
module user_module_341063825089364563 #(
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter logic [7:0] LFSR_TAPS   = 8'hB8
) (
    user_module_341063825089364563_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_LFSR = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic       clk_i;
    logic       rst_ni;
    mode_e      mode_i;
    logic [3:0] d_i;

    logic [7:0] q_q;
    logic [7:0] q_d;
    logic [7:0] step;
    logic       lfsr_fb;

    assign clk_i  = bus.io_in[0];
    assign rst_ni = bus.io_in[1];
    assign mode_i = mode_e'(bus.io_in[3:2]);
    assign d_i    = bus.io_in[7:4];

    // A zero nibble still advances the counter by one.
    assign step    = (d_i == 4'd0) ? 8'd1 : {4'd0, d_i};
    assign lfsr_fb = ^(q_q & LFSR_TAPS);

    // Next-state selection by mode; arithmetic wraps modulo 256 silently.
    always_comb begin
        q_d = q_q;
        unique case (mode_i)
            MODE_UP:   q_d = q_q + step;
            MODE_DOWN: q_d = q_q - step;
            MODE_LFSR: begin
                // All-zero is the LFSR lock-up state; kick it to 01 instead of shifting.
                if (q_q == 8'd0) begin
                    q_d = 8'd1;
                end else begin
                    q_d = {q_q[6:0], lfsr_fb};
                end
            end
            MODE_LOAD: q_d = {q_q[3:0], d_i};
            default:   q_d = q_q;
        endcase
    end

    // State register; reset is asynchronous and overrides any coincident edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.io_out = q_q;

endmodule

// File: tb/tb_user_module_341063825089364563.sv
// Directed bench for the sequence generator. Expected Q values are pushed
// into exp_q as each edge is set up; the monitor pops one per rising edge.
module tb_user_module_341063825089364563;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] d;

    int checks;
    int errors;
    logic [7:0] exp_q[$];

    user_module_341063825089364563_if bus ();

    assign bus.io_in = {d, mode, rst_n, clk};

    user_module_341063825089364563 dut (
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: act=%02h req=%02h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    // Q is valid 1 time unit after each rising edge; one expectation per edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                check("edge", bus.io_out, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge: set inputs for the coming rising edge,
    // register its expected result, return at the next falling edge.
    task automatic drive(input logic [1:0] m, input logic [3:0] nib, input logic [7:0] req);
        mode = m;
        d    = nib;
        exp_q.push_back(req);
        @(negedge clk);
    endtask

    // Called at a falling edge: pulse reset across one rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", bus.io_out, 8'h00);
        @(negedge clk);
        check("reset_held_edge", bus.io_out, 8'h00);
        rst_n = 1'b1;
    endtask

    // Independent model of x^8+x^6+x^5+x^4+1 with the lock-up escape.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        if (s == 8'h00) return 8'h01;
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] model;
        bit         seen[256];
        int         distinct;
        int         dups;
        int         budget;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        mode   = 2'b00;
        d      = 4'h0;

        // Reset held with clock running.
        #1;
        check("reset_t0", bus.io_out, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", bus.io_out, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Up-count by one, then load F5 and wrap by F.
        drive(2'b00, 4'h0, 8'h01);
        drive(2'b00, 4'h0, 8'h02);
        drive(2'b00, 4'h0, 8'h03);
        drive(2'b11, 4'hF, 8'h3F);
        drive(2'b11, 4'h5, 8'hF5);
        drive(2'b00, 4'hF, 8'h04);

        // Load 37, then pulse reset between edges.
        drive(2'b11, 4'h3, 8'h43);
        drive(2'b11, 4'h7, 8'h37);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_count", bus.io_out, 8'h00);
        @(negedge clk);
        check("reset_mid_held", bus.io_out, 8'h00);
        rst_n = 1'b1;

        // Down-count with wrap.
        drive(2'b01, 4'h0, 8'hFF);
        drive(2'b01, 4'h2, 8'hFD);

        // LFSR escape and first shifts.
        do_reset();
        drive(2'b10, 4'h0, 8'h01);
        drive(2'b10, 4'h0, 8'h02);
        drive(2'b10, 4'h0, 8'h04);

        // B8 -> 70.
        drive(2'b11, 4'hB, 8'h4B);
        drive(2'b11, 4'h8, 8'hB8);
        drive(2'b10, 4'h0, 8'h70);

        // Full period from 01.
        do_reset();
        drive(2'b10, 4'h0, 8'h01);
        model = 8'h01;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        distinct = 0;
        dups     = 0;
        for (int i = 0; i < 255; i++) begin
            model = lfsr_next(model);
            drive(2'b10, 4'h0, model);
            if (seen[bus.io_out]) dups++;
            else distinct++;
            seen[bus.io_out] = 1'b1;
        end
        check("lfsr_period_end", bus.io_out, 8'h01);
        check("lfsr_distinct", 8'(distinct), 8'd255);
        check("lfsr_dups", 8'(dups), 8'd0);
        check("lfsr_zero_unseen", {7'd0, seen[0]}, 8'd0);

        // Nibble load then count up.
        drive(2'b11, 4'hA, 8'h1A);
        drive(2'b11, 4'h5, 8'hA5);
        drive(2'b00, 4'h0, 8'hA6);

        // Mode alternating every edge.
        do_reset();
        drive(2'b00, 4'h0, 8'h01);
        drive(2'b01, 4'h0, 8'h00);
        drive(2'b00, 4'h0, 8'h01);
        drive(2'b01, 4'h0, 8'h00);

        // Drain scoreboard with a bounded wait.
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: act=%0d pending req=0 pending", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
